// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and transmitter handshake bundle for uart_tx_arbiter.
// master = byte sources and transmitter side, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_full;
  logic              echo_we;
  logic [DATA_W-1:0] echo_data;
  logic              echo_full;
  logic              tx_done_tick;
  logic              tx_start;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              cpu_ovf;
  logic              echo_ovf;

  modport master (
    output cpu_we, cpu_data, echo_we, echo_data, tx_done_tick,
    input  cpu_full, echo_full, tx_start, din, busy, cpu_ovf, echo_ovf
  );

  modport slave (
    input  cpu_we, cpu_data, echo_we, echo_data, tx_done_tick,
    output cpu_full, echo_full, tx_start, din, busy, cpu_ovf, echo_ovf
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a CPU byte FIFO and a receive-echo FIFO.
// Define UART_ECHO_EN to build the echo FIFO and round-robin arbitration; otherwise CPU only.
module uart_tx_arbiter_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     wr_q;
  logic [AW:0]       cnt_q;
  logic              ovf_q;
  logic              push;

  // A full FIFO still accepts a write when it is popped on the same edge.
  assign push = we_i && ((cnt_q != FULL_CNT) || pop_i);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push)  wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW + 1)'(push) - (AW + 1)'(pop_i);
      if (we_i && !push) ovf_q <= 1'b1;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign ovf_o   = ovf_q;
endmodule

module uart_tx_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

  state_e            state_q;
  logic              tx_start_q;
  logic              busy_q;
  logic [DATA_W-1:0] din_q;

  logic              cpu_pop;
  logic              cpu_empty;
  logic              cpu_full;
  logic              cpu_ovf;
  logic [DATA_W-1:0] cpu_head;
  logic              grant;
  logic [DATA_W-1:0] grant_data;

  uart_tx_arbiter_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_cpu_fifo (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.cpu_we),
    .data_i  (bus.cpu_data),
    .pop_i   (cpu_pop),
    .head_o  (cpu_head),
    .empty_o (cpu_empty),
    .full_o  (cpu_full),
    .ovf_o   (cpu_ovf)
  );

`ifdef UART_ECHO_EN
  typedef enum logic {GRANT_CPU, GRANT_ECHO} grant_e;

  grant_e            last_q;
  logic              echo_pop;
  logic              echo_empty;
  logic              echo_full;
  logic              echo_ovf;
  logic [DATA_W-1:0] echo_head;

  uart_tx_arbiter_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_echo_fifo (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.echo_we),
    .data_i  (bus.echo_data),
    .pop_i   (echo_pop),
    .head_o  (echo_head),
    .empty_o (echo_empty),
    .full_o  (echo_full),
    .ovf_o   (echo_ovf)
  );

  // On a tie the source not granted last time wins.
  always_comb begin
    cpu_pop  = 1'b0;
    echo_pop = 1'b0;
    if (state_q == IDLE) begin
      if (!cpu_empty && (echo_empty || last_q == GRANT_ECHO)) cpu_pop = 1'b1;
      else if (!echo_empty)                                  echo_pop = 1'b1;
    end
  end

  assign grant      = cpu_pop || echo_pop;
  assign grant_data = echo_pop ? echo_head : cpu_head;

  always_ff @(posedge clk) begin
    if (reset)         last_q <= GRANT_ECHO;
    else if (cpu_pop)  last_q <= GRANT_CPU;
    else if (echo_pop) last_q <= GRANT_ECHO;
  end

  assign bus.echo_full = echo_full;
  assign bus.echo_ovf  = echo_ovf;
`else
  logic unused_echo;

  assign unused_echo   = ^{bus.echo_we, bus.echo_data};
  assign cpu_pop       = (state_q == IDLE) && !cpu_empty;
  assign grant         = cpu_pop;
  assign grant_data    = cpu_head;
  assign bus.echo_full = 1'b0;
  assign bus.echo_ovf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      din_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        IDLE: if (grant) begin
          state_q    <= START;
          tx_start_q <= 1'b1;
          busy_q     <= 1'b1;
          din_q      <= grant_data;
        end
        START: state_q <= WAIT;
        WAIT: if (bus.tx_done_tick) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.din      = din_q;
  assign bus.cpu_full = cpu_full;
  assign bus.cpu_ovf  = cpu_ovf;
endmodule
